// File: rtl/nios2_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI memory arbiter and its JTAG command buffer.
package nios2_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_J_ACC,
    ST_C_ACC,
    ST_RD_WAIT
  } ocimem_state_t;

  typedef enum logic {
    GNT_JTAG,
    GNT_CPU
  } gnt_t;

  localparam int JDO_W           = 38;
  localparam int JDO_WR_BIT      = 35;
  localparam int JDO_DATA_LSB    = 3;
  localparam int JDO_ADDR_LSB    = 8;
  localparam int JDO_AUTOINC_BIT = 1;

endpackage

// File: rtl/nios2_ocimem_jtag_cmd.sv
// One-deep JTAG command buffer: address/auto-increment, pending access, monitor result and flags.
// Accepts on the _b strobe in one cycle; a _b arriving while busy (not completing) is dropped as an overrun.
module nios2_ocimem_jtag_cmd
  import nios2_ocimem_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_a,
  input  logic              take_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              done,
  input  logic              done_rd,
  input  logic [DW-1:0]     ram_rdata,
  output logic              jtag_pend,
  output logic [RAM_AW-1:0] acc_addr,
  output logic              acc_wr,
  output logic [DW-1:0]     acc_wdata,
  output logic [DW-1:0]     mon_dreg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  logic [RAM_AW-1:0] jtag_addr;
  logic              autoinc;
  logic              addr_reloaded;
  logic [RAM_AW-1:0] addr_inc;
  logic              inc_ok;
  logic              accept_b;
  logic              overrun;
  logic              unused_jdo;

  // A completing access frees the buffer in the same cycle, so a coincident _b is a new command.
  assign accept_b = take_b && (!jtag_pend || done);
  assign overrun  = take_b && jtag_pend && !done;
  assign addr_inc = jtag_addr + RAM_AW'(1);
  // An _a during the access already set the next address; don't bump it on completion.
  assign inc_ok   = autoinc && !addr_reloaded;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_WR_BIT+1], jdo[JDO_AUTOINC_BIT+1], jdo[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_addr     <= '0;
      autoinc       <= 1'b0;
      addr_reloaded <= 1'b0;
      jtag_pend     <= 1'b0;
      acc_addr      <= '0;
      acc_wr        <= 1'b0;
      acc_wdata     <= '0;
      mon_dreg      <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      if (take_a) begin
        jtag_addr <= jdo[JDO_ADDR_LSB +: RAM_AW];
        autoinc   <= jdo[JDO_AUTOINC_BIT];
      end else if (done && inc_ok) begin
        jtag_addr <= addr_inc;
      end

      addr_reloaded <= jtag_pend && !done && (addr_reloaded || take_a);

      if (accept_b) begin
        jtag_pend     <= 1'b1;
        monitor_ready <= 1'b0;
        acc_wr        <= jdo[JDO_WR_BIT];
        acc_wdata     <= jdo[JDO_DATA_LSB +: DW];
        acc_addr      <= (done && inc_ok) ? addr_inc : jtag_addr;
      end else if (done) begin
        jtag_pend     <= 1'b0;
        monitor_ready <= 1'b1;
      end

      if (overrun) begin
        monitor_error <= 1'b1;
      end else if (take_a) begin
        monitor_error <= 1'b0;
      end

      if (done_rd) begin
        mon_dreg <= ram_rdata;
      end
    end
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG and CPU; write = 1 access cycle, read = access + RD_WAIT.
// CPU stalled via cpu_waitrequest; JTAG round-robin vs CPU unless OCIMEM_JTAG_PRIORITY_EN makes JTAG always win.
module nios2_ocimem_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [RAM_AW-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DW-1:0]     cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DW-1:0]     cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic [DW-1:0]     MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_t     state, state_nxt;
  gnt_t              last_grant, grant_nxt;
  logic              jtag_pend;
  logic [RAM_AW-1:0] acc_addr;
  logic              acc_wr;
  logic [DW-1:0]     acc_wdata;
  logic              jtag_done;
  logic              jtag_done_rd;
  logic              jtag_req;
  logic              cpu_req;

  nios2_ocimem_jtag_cmd #(
    .RAM_AW (RAM_AW),
    .DW     (DW)
  ) u_jtag_cmd (
    .clk           (clk),
    .reset         (reset),
    .take_a        (take_action_ocimem_a),
    .take_b        (take_action_ocimem_b),
    .jdo           (jdo),
    .done          (jtag_done),
    .done_rd       (jtag_done_rd),
    .ram_rdata     (ram_rdata),
    .jtag_pend     (jtag_pend),
    .acc_addr      (acc_addr),
    .acc_wr        (acc_wr),
    .acc_wdata     (acc_wdata),
    .mon_dreg      (MonDReg),
    .monitor_ready (monitor_ready),
    .monitor_error (monitor_error)
  );

  // A fresh _b strobe competes in the same IDLE cycle so a JTAG access can start the next cycle.
  assign jtag_req        = jtag_pend || take_action_ocimem_b;
  assign cpu_req         = cpu_read || cpu_write;
  assign cpu_waitrequest = cpu_req && (state != ST_C_ACC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= GNT_CPU;
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    grant_nxt         = last_grant;
    ram_addr          = '0;
    ram_wren          = 1'b0;
    ram_wdata         = '0;
    jtag_done         = 1'b0;
    jtag_done_rd      = 1'b0;
    cpu_readdatavalid = 1'b0;
    cpu_readdata      = '0;

    unique case (state)
      ST_IDLE: begin
`ifdef OCIMEM_JTAG_PRIORITY_EN
        if (jtag_req) begin
`else
        if (jtag_req && (!cpu_req || last_grant == GNT_CPU)) begin
`endif
          state_nxt = ST_J_ACC;
          grant_nxt = GNT_JTAG;
        end else if (cpu_req) begin
          state_nxt = ST_C_ACC;
          grant_nxt = GNT_CPU;
        end
      end

      ST_J_ACC: begin
        ram_addr  = acc_addr;
        ram_wren  = acc_wr && !reset;
        ram_wdata = acc_wdata;
        jtag_done = acc_wr;
        state_nxt = acc_wr ? ST_IDLE : ST_RD_WAIT;
      end

      ST_C_ACC: begin
        ram_addr  = cpu_address;
        ram_wren  = cpu_write && !reset;
        ram_wdata = cpu_writedata;
        state_nxt = (!cpu_write && cpu_read) ? ST_RD_WAIT : ST_IDLE;
      end

      ST_RD_WAIT: begin
        // last_grant also records which side owns the read in flight.
        state_nxt = ST_IDLE;
        if (last_grant == GNT_CPU) begin
          cpu_readdatavalid = !reset;
          cpu_readdata      = ram_rdata;
        end else begin
          jtag_done    = 1'b1;
          jtag_done_rd = 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed scoreboard bench for nios2_ocimem_arbiter with a registered-read RAM model.
module tb_nios2_ocimem_arbiter;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_a;
  logic        take_b;
  logic [37:0] jdo;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  wr_t         wr_q[$];
  logic [31:0] cpu_q[$];
  logic [31:0] jtag_q[$];
  logic        prev_ready = 1'b1;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .jdo                  (jdo),
    .cpu_address          (cpu_address),
    .cpu_read             (cpu_read),
    .cpu_write            (cpu_write),
    .cpu_writedata        (cpu_writedata),
    .cpu_waitrequest      (cpu_waitrequest),
    .cpu_readdata         (cpu_readdata),
    .cpu_readdatavalid    (cpu_readdatavalid),
    .ram_addr             (ram_addr),
    .ram_wren             (ram_wren),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .monitor_error        (monitor_error)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'hC0DE0000 | {24'h0, a};
  endfunction

  function automatic logic [37:0] mk_a(input logic [7:0] a, input logic ai);
    return {22'h0, a, 6'h0, ai, 1'b0};
  endfunction

  function automatic logic [37:0] mk_b(input logic wr, input logic [31:0] d);
    return {2'b00, wr, d, 3'b000};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
  end

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [7:0] a, input logic ai);
    jdo    = mk_a(a, ai);
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  task automatic jtag_b(input logic wr, input logic [31:0] d);
    jdo    = mk_b(wr, d);
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (monitor_ready) seen = 1'b1;
    end
    check("ready_timeout", 32'(seen), 32'h1);
    tick();
  endtask

  task automatic wait_accept(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((cpu_read || cpu_write) && !cpu_waitrequest) seen = 1'b1;
    end
    check("cpu_accept_timeout", 32'(seen), 32'h1);
    tick();
  endtask

  // Monitor: every RAM write, CPU read return and monitor_ready rise is matched against the queues.
  always @(negedge clk) begin
    wr_t we;
    if (!reset) begin
      if (ram_wren) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ram_wr_unexpected: got addr %h data %h expected none", ram_addr, ram_wdata);
        end else begin
          we = wr_q.pop_front();
          check("ram_wr_addr", 32'(ram_addr), 32'(we.addr));
          check("ram_wr_data", ram_wdata, we.data);
        end
      end
      if (cpu_readdatavalid) begin
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_rdv_unexpected: got data %h expected none", cpu_readdata);
        end else begin
          check("cpu_readdata", cpu_readdata, cpu_q.pop_front());
        end
      end
      if (monitor_ready && !prev_ready) begin
        if (jtag_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL jtag_done_unexpected: got MonDReg %h expected none", MonDReg);
        end else begin
          check("MonDReg", MonDReg, jtag_q.pop_front());
        end
      end
    end
    prev_ready = monitor_ready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    take_a        = 1'b0;
    take_b        = 1'b0;
    jdo           = '0;
    cpu_address   = '0;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_writedata = '0;
    repeat (3) tick();

    check("rst_waitreq", 32'(cpu_waitrequest), 32'h0);
    check("rst_rdv", 32'(cpu_readdatavalid), 32'h0);
    check("rst_rdata", cpu_readdata, 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_wren", 32'(ram_wren), 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_ready", 32'(monitor_ready), 32'h1);
    check("rst_error", 32'(monitor_error), 32'h0);
    reset = 1'b0;
    tick();

    // JTAG write then read of 0x10.
    jtag_a(8'h10, 1'b0);
    wr_q.push_back('{8'h10, 32'hDEADBEEF});
    jtag_q.push_back(32'h0);
    jtag_b(1'b1, 32'hDEADBEEF);
    check("jw_wren_n1", 32'(ram_wren), 32'h1);
    check("jw_addr_n1", 32'(ram_addr), 32'h10);
    check("jw_ready_n1", 32'(monitor_ready), 32'h0);
    tick();
    check("jw_ready_n2", 32'(monitor_ready), 32'h1);
    jtag_q.push_back(32'hDEADBEEF);
    jtag_b(1'b0, 32'h0);
    check("jr_addr_n1", 32'(ram_addr), 32'h10);
    check("jr_ready_n1", 32'(monitor_ready), 32'h0);
    tick();
    check("jr_ready_n2", 32'(monitor_ready), 32'h0);
    tick();
    check("jr_ready_n3", 32'(monitor_ready), 32'h1);
    check("jr_mondreg_n3", MonDReg, 32'hDEADBEEF);
    tick();

    // Auto-increment wraps 0xFF -> 0x00.
    jtag_a(8'hFE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] a;
      a = 8'(8'hFE + i);
      jtag_q.push_back(pat(a));
      jtag_b(1'b0, 32'h0);
      check("ai_ram_addr", 32'(ram_addr), 32'(a));
      wait_ready(10);
    end

    // Overrun: second _b while the read is pending is dropped (no RAM write may appear).
    jtag_a(8'h30, 1'b0);
    jtag_q.push_back(pat(8'h30));
    jtag_b(1'b0, 32'h0);
    jtag_b(1'b1, 32'h00000055);
    check("ovr_error_set", 32'(monitor_error), 32'h1);
    wait_ready(10);
    check("ovr_error_sticky", 32'(monitor_error), 32'h1);
    jtag_a(8'h30, 1'b0);
    check("ovr_error_clr", 32'(monitor_error), 32'h0);

    // CPU write then read of 0x20.
    wr_q.push_back('{8'h20, 32'h12345678});
    cpu_address   = 8'h20;
    cpu_writedata = 32'h12345678;
    cpu_write     = 1'b1;
    wait_accept(10);
    cpu_write = 1'b0;
    cpu_q.push_back(32'h12345678);
    cpu_read = 1'b1;
    #1;
    check("cr_wait_idle", 32'(cpu_waitrequest), 32'h1);
    wait_accept(10);
    check("cr_rdv_next", 32'(cpu_readdatavalid), 32'h1);
    check("cr_rdata_next", cpu_readdata, 32'h12345678);
    cpu_read = 1'b0;
    tick();

    // Reset in RD_WAIT of a CPU read aborts it.
    cpu_read = 1'b1;
    wait_accept(10);
    cpu_read = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_rdwait_no_rdv", 32'(cpu_readdatavalid), 32'h0);
    tick();
    reset = 1'b0;
    check("rst2_ready", 32'(monitor_ready), 32'h1);
    check("rst2_rdv", 32'(cpu_readdatavalid), 32'h0);
    check("rst2_mondreg", MonDReg, 32'h0);
    cpu_q.push_back(32'h12345678);
    cpu_read = 1'b1;
    #1;
    check("rst2_idle_wait", 32'(cpu_waitrequest), 32'h1);
    tick();
    check("rst2_cacc_nowait", 32'(cpu_waitrequest), 32'h0);
    tick();
    check("rst2_rdv", 32'(cpu_readdatavalid), 32'h1);
    cpu_read = 1'b0;
    tick();

    // Sustained contention: JTAG _b also lands in each JTAG completion cycle.
`ifdef OCIMEM_JTAG_PRIORITY_EN
    wr_q.push_back('{8'h40, 32'hA0000000});
    wr_q.push_back('{8'h41, 32'hA0000001});
    wr_q.push_back('{8'h50, 32'hC0000000});
    wr_q.push_back('{8'h42, 32'hA0000002});
    wr_q.push_back('{8'h51, 32'hC0000001});
    wr_q.push_back('{8'h52, 32'hC0000002});
    jtag_q.push_back(32'h0);
    jtag_q.push_back(32'h0);
`else
    wr_q.push_back('{8'h40, 32'hA0000000});
    wr_q.push_back('{8'h50, 32'hC0000000});
    wr_q.push_back('{8'h41, 32'hA0000001});
    wr_q.push_back('{8'h51, 32'hC0000001});
    wr_q.push_back('{8'h42, 32'hA0000002});
    wr_q.push_back('{8'h52, 32'hC0000002});
    jtag_q.push_back(32'h0);
`endif
    jtag_a(8'h40, 1'b1);
    fork
      begin
        int idx = 0;
        for (int c = 0; c < 6; c++) begin
          take_b = (c == 0 || c == 1 || c == 5);
          jdo    = mk_b(1'b1, 32'hA0000000 + 32'(idx));
          if (take_b) idx++;
          tick();
        end
        take_b = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) begin
          cpu_address   = 8'(8'h50 + i);
          cpu_writedata = 32'hC0000000 + 32'(i);
          cpu_write     = 1'b1;
          wait_accept(20);
        end
        cpu_write = 1'b0;
      end
    join
    wait_ready(40);
    check("cont_no_error", 32'(monitor_error), 32'h0);

    repeat (4) tick();
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    check("jtag_q_drained", 32'(jtag_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
